pq_symbol_serializer: RTL and testbench

PQ_SYMBOL_SERIALIZER -- requirements
Module: pq_symbol_serializer

---
 rtl/pq_pkg.sv | 14 +
 rtl/pq_symbol_serializer.sv | 131 +++++++++++++
 tb/tb_pq_symbol_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types for the packed-word symbol serializer: symbol width,
// symbol type and the serializer FSM state encoding.
package pq_pkg;

    localparam int SYMBOL_W = 4;

    typedef logic [SYMBOL_W-1:0] pq_sym_t;

    typedef enum logic [0:0] {
        PQ_IDLE = 1'b0,
        PQ_SEND = 1'b1
    } pq_state_e;

endpackage

// File: rtl/pq_symbol_serializer.sv
// Accepts a packed word of PQ_SYMBOLS 4-bit symbols and emits them LSB-first
// over a valid/ready symbol stream, allowing back-to-back words without a bubble.
module pq_symbol_serializer
    import pq_pkg::*;
#(
    parameter int PQ_SYMBOLS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [PQ_SYMBOLS*SYMBOL_W-1:0] i_all_symbols_4b,
    input  logic                           i_valid,
    output logic                           o_ready,
    output pq_sym_t                        o_sym,
    output logic                           o_sym_valid,
    input  logic                           i_sym_ready,
    output logic                           o_sym_last,
    output logic [$clog2(PQ_SYMBOLS)-1:0]  o_sym_idx
);

    localparam int WORD_W = PQ_SYMBOLS * SYMBOL_W;
    localparam int IDX_W  = $clog2(PQ_SYMBOLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PQ_SYMBOLS - 1);

    pq_state_e         state_r;
    pq_state_e         state_nxt_s;
    logic [WORD_W-1:0] word_r;
    logic [WORD_W-1:0] word_nxt_s;
    pq_sym_t           sym_r;
    pq_sym_t           sym_nxt_s;
    logic              sym_valid_r;
    logic              sym_valid_nxt_s;
    logic              sym_last_r;
    logic              sym_last_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              ready_s;
    logic              accept_s;
    logic              sym_acc_s;

    // Acceptance handshakes; a new word may land in the same cycle the last symbol leaves.
    always_comb begin
        ready_s   = i_rst_n & i_en &
                    ((state_r == PQ_IDLE) | (sym_valid_r & i_sym_ready & sym_last_r));
        accept_s  = i_valid & ready_s;
        sym_acc_s = sym_valid_r & i_sym_ready;
    end

    assign o_ready     = ready_s;
    assign o_sym       = sym_r;
    assign o_sym_valid = sym_valid_r;
    assign o_sym_last  = sym_last_r;
    assign o_sym_idx   = idx_r;

    // Next-state and output-register logic.
    always_comb begin
        state_nxt_s     = state_r;
        word_nxt_s      = word_r;
        sym_nxt_s       = sym_r;
        sym_valid_nxt_s = sym_valid_r;
        sym_last_nxt_s  = sym_last_r;
        idx_nxt_s       = idx_r;
        case (state_r)
            PQ_IDLE: begin
                if (accept_s) begin
                    state_nxt_s     = PQ_SEND;
                    word_nxt_s      = i_all_symbols_4b;
                    sym_nxt_s       = i_all_symbols_4b[SYMBOL_W-1:0];
                    sym_valid_nxt_s = 1'b1;
                    sym_last_nxt_s  = 1'b0;
                    idx_nxt_s       = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = PQ_IDLE;
                end
            end
            PQ_SEND: begin
                if (accept_s) begin
                    word_nxt_s      = i_all_symbols_4b;
                    sym_nxt_s       = i_all_symbols_4b[SYMBOL_W-1:0];
                    sym_valid_nxt_s = 1'b1;
                    sym_last_nxt_s  = 1'b0;
                    idx_nxt_s       = {IDX_W{1'b0}};
                end else if (sym_acc_s) begin
                    if (sym_last_r) begin
                        state_nxt_s     = PQ_IDLE;
                        sym_nxt_s       = {SYMBOL_W{1'b0}};
                        sym_valid_nxt_s = 1'b0;
                        sym_last_nxt_s  = 1'b0;
                        idx_nxt_s       = {IDX_W{1'b0}};
                    end else begin
                        // Held word shifts down so the next symbol is always at bits [7:4].
                        word_nxt_s     = word_r >> SYMBOL_W;
                        sym_nxt_s      = word_r[2*SYMBOL_W-1:SYMBOL_W];
                        idx_nxt_s      = idx_r + IDX_W'(1);
                        sym_last_nxt_s = ((idx_r + IDX_W'(1)) == LAST_IDX);
                    end
                end else begin
                    state_nxt_s = PQ_SEND;
                end
            end
            default: begin
                state_nxt_s     = PQ_IDLE;
                word_nxt_s      = {WORD_W{1'b0}};
                sym_nxt_s       = {SYMBOL_W{1'b0}};
                sym_valid_nxt_s = 1'b0;
                sym_last_nxt_s  = 1'b0;
                idx_nxt_s       = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r     <= PQ_IDLE;
            word_r      <= {WORD_W{1'b0}};
            sym_r       <= {SYMBOL_W{1'b0}};
            sym_valid_r <= 1'b0;
            sym_last_r  <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            word_r      <= word_nxt_s;
            sym_r       <= sym_nxt_s;
            sym_valid_r <= sym_valid_nxt_s;
            sym_last_r  <= sym_last_nxt_s;
            idx_r       <= idx_nxt_s;
        end
    end

endmodule

// File: tb/tb_pq_symbol_serializer.sv
// Directed-vector bench for pq_symbol_serializer with PQ_SYMBOLS=4; every
// expected symbol, index and flag below is worked out by hand from the word.
module tb_pq_symbol_serializer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] word;
    logic        valid;
    logic        ready;
    logic [3:0]  sym;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_last;
    logic [1:0]  sym_idx;

    int n_vec;
    int n_err;

    pq_symbol_serializer #(.PQ_SYMBOLS(4)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_en             (en),
        .i_all_symbols_4b (word),
        .i_valid          (valid),
        .o_ready          (ready),
        .o_sym            (sym),
        .o_sym_valid      (sym_valid),
        .i_sym_ready      (sym_ready),
        .o_sym_last       (sym_last),
        .o_sym_idx        (sym_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_sym(input string tag, input logic [3:0] s, input logic [1:0] k,
                              input logic l);
        chk({tag, ".valid"}, 16'(sym_valid), 16'h1);
        chk({tag, ".sym"}, 16'(sym), 16'(s));
        chk({tag, ".idx"}, 16'(sym_idx), 16'(k));
        chk({tag, ".last"}, 16'(sym_last), 16'(l));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] w);
        word  = w;
        valid = 1'b1;
        #1;
        chk("offer.ready", 16'(ready), 16'h1);
        tick();
        valid = 1'b0;
        word  = 16'h0000;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        valid     = 1'b1;
        word      = 16'hFFFF;
        sym_ready = 1'b1;

        tick();
        tick();
        chk("rst.ready", 16'(ready), 16'h0);
        chk("rst.valid", 16'(sym_valid), 16'h0);
        chk("rst.sym", 16'(sym), 16'h0);
        chk("rst.idx", 16'(sym_idx), 16'h0);
        chk("rst.last", 16'(sym_last), 16'h0);
        valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle.valid", 16'(sym_valid), 16'h0);

        // Free-running stream of 16'hA5C3; input bus cleared right after capture.
        offer(16'hA5C3);
        expect_sym("a5c3.s0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_sym("a5c3.s1", 4'hC, 2'd1, 1'b0);
        tick();
        expect_sym("a5c3.s2", 4'h5, 2'd2, 1'b0);
        tick();
        expect_sym("a5c3.s3", 4'hA, 2'd3, 1'b1);
        tick();
        chk("a5c3.done", 16'(sym_valid), 16'h0);

        // Downstream stalls three cycles on symbol index 1.
        offer(16'hA5C3);
        expect_sym("stall.s0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_sym("stall.s1", 4'hC, 2'd1, 1'b0);
        sym_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sym("stall.hold", 4'hC, 2'd1, 1'b0);
        end
        sym_ready = 1'b1;
        tick();
        expect_sym("stall.s2", 4'h5, 2'd2, 1'b0);
        tick();
        expect_sym("stall.s3", 4'hA, 2'd3, 1'b1);
        tick();
        chk("stall.done", 16'(sym_valid), 16'h0);

        // Back-to-back words with valid held high throughout.
        word  = 16'h1234;
        valid = 1'b1;
        #1;
        chk("b2b.ready0", 16'(ready), 16'h1);
        tick();
        word = 16'hFEDC;
        expect_sym("b2b.s0", 4'h4, 2'd0, 1'b0);
        chk("b2b.busy", 16'(ready), 16'h0);
        tick();
        expect_sym("b2b.s1", 4'h3, 2'd1, 1'b0);
        tick();
        expect_sym("b2b.s2", 4'h2, 2'd2, 1'b0);
        tick();
        expect_sym("b2b.s3", 4'h1, 2'd3, 1'b1);
        chk("b2b.ready_last", 16'(ready), 16'h1);
        tick();
        valid = 1'b0;
        expect_sym("b2b.s4", 4'hC, 2'd0, 1'b0);
        tick();
        expect_sym("b2b.s5", 4'hD, 2'd1, 1'b0);
        tick();
        expect_sym("b2b.s6", 4'hE, 2'd2, 1'b0);
        tick();
        expect_sym("b2b.s7", 4'hF, 2'd3, 1'b1);
        tick();
        chk("b2b.done", 16'(sym_valid), 16'h0);

        // Enable low blocks acceptance from IDLE.
        en    = 1'b0;
        valid = 1'b1;
        word  = 16'h1111;
        #1;
        chk("en0.ready", 16'(ready), 16'h0);
        tick();
        tick();
        chk("en0.valid", 16'(sym_valid), 16'h0);
        valid = 1'b0;
        en    = 1'b1;

        // Enable dropped mid-word: current word finishes, the next is refused.
        offer(16'h8765);
        expect_sym("enmid.s0", 4'h5, 2'd0, 1'b0);
        en    = 1'b0;
        valid = 1'b1;
        word  = 16'h4321;
        tick();
        expect_sym("enmid.s1", 4'h6, 2'd1, 1'b0);
        tick();
        expect_sym("enmid.s2", 4'h7, 2'd2, 1'b0);
        tick();
        expect_sym("enmid.s3", 4'h8, 2'd3, 1'b1);
        chk("enmid.ready", 16'(ready), 16'h0);
        tick();
        chk("enmid.done", 16'(sym_valid), 16'h0);
        tick();
        chk("enmid.idle", 16'(sym_valid), 16'h0);
        valid = 1'b0;
        en    = 1'b1;

        // Reset at the edge that accepts symbol index 1 discards the rest.
        offer(16'h9ABC);
        expect_sym("rstmid.s0", 4'hC, 2'd0, 1'b0);
        tick();
        expect_sym("rstmid.s1", 4'hB, 2'd1, 1'b0);
        rst_n = 1'b0;
        valid = 1'b1;
        #1;
        chk("rstmid.ready", 16'(ready), 16'h0);
        tick();
        valid = 1'b0;
        chk("rstmid.valid", 16'(sym_valid), 16'h0);
        chk("rstmid.sym", 16'(sym), 16'h0);
        chk("rstmid.idx", 16'(sym_idx), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid.quiet", 16'(sym_valid), 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
